// File: rtl/param_memory_if.sv
// param_memory_if: cache-side line-burst bus between the hierarchy and the memory model
interface param_memory_if;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;
    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/param_memory.sv
// param_memory: burst main-memory model with programmable latency; define PARAM_MEM_PAGE_EN for open-page hit latency
module param_memory #(
    parameter int MISS_DELAY  = 50,
    parameter int HIT_DELAY   = 25,
    parameter int BURST_LEN   = 4,
    parameter int LINE_BITS   = 256,
    parameter int PAGE_BYTES  = 512,
    parameter int DEPTH_LINES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    param_memory_if.slave bus
);
    localparam int OB = $clog2(LINE_BITS / 8);
    localparam int LW = $clog2(DEPTH_LINES);
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam int CW = $clog2(MISS_DELAY > HIT_DELAY ? MISS_DELAY : HIT_DELAY) + 1;

    if (BURST_LEN * 64 != LINE_BITS || PAGE_BYTES < LINE_BITS / 8) begin : g_bad_cfg
        $error("param_memory: BURST_LEN*64 must equal LINE_BITS and a page must hold a line");
    end

    // The FSM runs one cycle ahead of the registered outputs: BURST here means
    // "beat presented next cycle", so DONE overlaps the last visible beat and the
    // turnaround cycle seen on the bus is the IDLE-bound cycle after it.
    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d, delay;
    logic [BW-1:0] beat, beat_d, beat_q;
    logic [LW-1:0] line;
    logic          is_wr, accept, resp;
    logic [63:0]   rdata;
    logic [63:0]   mem [DEPTH_LINES][BURST_LEN] = '{default: '0};

`ifdef PARAM_MEM_PAGE_EN
    localparam int PB = $clog2(PAGE_BYTES);
    logic [31-PB:0] page_q;
    logic           page_vld;

    assign delay = (page_vld && page_q == bus.pmem_address[31:PB]) ? CW'(HIT_DELAY) : CW'(MISS_DELAY);

    // open row follows every accepted request; reset forgets it
    always_ff @(posedge clk) begin
        if (!rst) begin
            page_vld <= 1'b0;
        end else if (accept) begin
            page_vld <= 1'b1;
            page_q   <= bus.pmem_address[31:PB];
        end
    end
`else
    assign delay = CW'(MISS_DELAY);
`endif

    // next-state: accept in IDLE, count down the latency, step through the beats
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        beat_d  = beat;
        accept  = 1'b0;
        case (state)
            IDLE: if (bus.pmem_read || bus.pmem_write) begin
                accept  = 1'b1;
                state_d = (delay == CW'(1)) ? BURST : WAIT;
                cnt_d   = delay - CW'(2);
                beat_d  = '0;
            end
            WAIT: begin
                state_d = (cnt == '0) ? BURST : WAIT;
                cnt_d   = cnt - 1'b1;
            end
            BURST: begin
                state_d = (beat == BW'(BURST_LEN - 1)) ? DONE : BURST;
                beat_d  = beat + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register, request capture and registered beat outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            resp  <= 1'b0;
            rdata <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            beat   <= beat_d;
            beat_q <= beat;
            resp   <= state == BURST;
            rdata  <= (state == BURST && !is_wr) ? mem[line][beat] : '0;
            if (accept) begin
                line  <= bus.pmem_address[OB +: LW];
                is_wr <= !bus.pmem_read;
            end
        end
    end

    // a write beat lands on the edge closing its strobe cycle, unless reset wins
    always_ff @(posedge clk) begin
        if (rst && resp && is_wr) mem[line][beat_q] <= bus.pmem_wdata;
    end

    assign bus.pmem_resp  = resp;
    assign bus.pmem_rdata = rdata;
endmodule

// File: tb/tb_param_memory.sv
// tb_param_memory: randomized scoreboard bench for the burst memory model
module tb_param_memory;
`ifdef PARAM_MEM_PAGE_EN
    localparam bit PAGE_EN = 1'b1;
`else
    localparam bit PAGE_EN = 1'b0;
`endif
    localparam int MISS = 50;
    localparam int HIT  = 25;

    typedef struct {
        int           cyc0;
        int           nb;
        bit           chk;
        logic [255:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    param_memory_if bus ();

    param_memory dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int free_at = 0;
    logic [255:0] ref_mem [1024];
    logic [31:0] opage;
    bit pvld = 1'b0;
    exp_t q [$];
    exp_t cur;
    int bi = 0;
    bit act = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc > 80000) begin
            $display("FAIL watchdog: cycle %0d exceeded budget 80000", cyc);
            $fatal(1);
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // monitor: every strobe cycle is matched against the oldest expected burst
    always @(negedge clk) begin
        if (bus.pmem_resp) begin
            if (!act) begin
                if (q.size() == 0) begin
                    chk("resp_without_request", {63'b0, bus.pmem_resp}, 64'd0);
                end else begin
                    cur = q.pop_front();
                    act = 1'b1;
                    bi = 0;
                end
            end
            if (act) begin
                chk("beat_cycle", 64'(cyc), 64'(cur.cyc0 + bi));
                if (cur.chk) chk("rdata_beat", bus.pmem_rdata, cur.data[64*bi +: 64]);
                bi++;
                if (bi == cur.nb) act = 1'b0;
            end
        end else begin
            chk("idle_rdata_zero", bus.pmem_rdata, 64'd0);
            if (act) begin
                chk("burst_length", 64'(bi), 64'(cur.nb));
                act = 1'b0;
            end
        end
    end

    // issue one request at a negedge; the model predicts the acceptance edge and latency
    task automatic req(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [255:0] wd, input int abort_at, input bit keep);
        int a, d, ln;
        logic [31:0] pg;
        exp_t e;
        bus.pmem_read = rd;
        bus.pmem_write = wr;
        bus.pmem_address = addr;
        a = (cyc + 1 > free_at) ? cyc + 1 : free_at;
        while (cyc < a) @(negedge clk);
        if (!keep) begin
            bus.pmem_read = 1'b0;
            bus.pmem_write = 1'b0;
            bus.pmem_address = $urandom;
        end
        ln = int'(addr[14:5]);
        pg = addr >> 9;
        d = (PAGE_EN && pvld && pg == opage) ? HIT : MISS;
        opage = pg;
        pvld = 1'b1;
        e.cyc0 = a + d;
        e.nb = (abort_at < 0) ? 4 : abort_at + 1;
        e.chk = rd;
        e.data = ref_mem[ln];
        q.push_back(e);
        free_at = a + d + 5;
        if (!rd && wr) begin
            for (int k = 0; k < 4; k++) begin
                while (cyc < a + d + k) @(negedge clk);
                bus.pmem_wdata = wd[64*k +: 64];
                if (k == abort_at) begin
                    rst = 1'b0;
                    @(negedge clk);
                    rst = 1'b1;
                    pvld = 1'b0;
                    free_at = cyc + 1;
                    bus.pmem_wdata = {$urandom, $urandom};
                    return;
                end
                ref_mem[ln][64*k +: 64] = wd[64*k +: 64];
            end
            @(negedge clk);
            bus.pmem_wdata = {$urandom, $urandom};
        end
    endtask

    function automatic logic [255:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [31:0] ra;
        int op;
        rst = 1'b0;
        bus.pmem_read = 1'b0;
        bus.pmem_write = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_resp", {63'b0, bus.pmem_resp}, 64'd0);
        chk("reset_rdata", bus.pmem_rdata, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        req(1'b0, 1'b1, 32'h100, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, -1, 1'b0);
        req(1'b1, 1'b0, 32'h100, '0, -1, 1'b0);
        req(1'b1, 1'b0, 32'h400, '0, -1, 1'b0);
        req(1'b1, 1'b0, 32'h000, '0, -1, 1'b0);
        req(1'b1, 1'b1, 32'h100, rnd_line(), -1, 1'b0);
        req(1'b1, 1'b0, 32'h100, '0, -1, 1'b0);
        for (int i = 0; i < 3; i++) req(1'b1, 1'b0, 32'h2e0, '0, -1, 1'b1);
        bus.pmem_read = 1'b0;
        req(1'b0, 1'b1, 32'h200, rnd_line(), -1, 1'b0);
        req(1'b0, 1'b1, 32'h200, rnd_line(), 2, 1'b0);
        req(1'b1, 1'b0, 32'h200, '0, -1, 1'b0);
        req(1'b1, 1'b0, 32'h100, '0, -1, 1'b0);
        req(1'b1, 1'b0, 32'h100, '0, -1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31));
            if ($urandom_range(0, 4) == 0) ra = ra | (32'($urandom_range(1, 7)) << 20);
            op = $urandom_range(0, 2);
            req(op != 1, op != 0, ra, rnd_line(), -1, 1'b0);
        end
        while (cyc < free_at + 3) @(negedge clk);
        chk("queue_drained", 64'(q.size() + int'(act)), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/param_memory.md
# param_memory

Burst-mode, cycle-accurate main-memory model that stands in for physical memory behind the cache hierarchy. It serves whole cache lines as a 4-beat × 64-bit burst after a programmable latency. A shorter latency applies when the access falls in the currently open page (row-buffer hit). Instantiated by the top-level testbench as the parameterised alternative to the dual-port magic memory, with the default configuration MISS_DELAY=50, HIT_DELAY=25, BURST_LEN=4, LINE_BITS=256, PAGE_BYTES=512.

## Interface
- MISS_DELAY, 50: cycles from request acceptance to the first beat on a page miss (≥1).
- HIT_DELAY, 25: cycles from request acceptance to the first beat on a page hit (≥1).
- BURST_LEN, 4: beats per line; must equal LINE_BITS/64.
- LINE_BITS, 256: cache-line width in bits.
- PAGE_BYTES, 512: open-page (row) size in bytes; power of two, ≥ LINE_BITS/8.
- DEPTH_LINES, 1024: storage capacity in lines; power of two.
- clk  in  1  clock; all activity occurs on the rising edge.
- rst  in  1  reset; synchronous and active-low.
- pmem_read  in  1  read-line request.
- pmem_write  in  1  write-line request.
- pmem_address  in  32  byte address; the low log2(LINE_BITS/8) bits are ignored.
- pmem_wdata  in  64  write beat.
- pmem_rdata  out  64  read beat; valid while pmem_resp=1, otherwise 0.
- pmem_resp  out  1  beat strobe; high for exactly BURST_LEN consecutive cycles per request.

## Operation
- States:
  - IDLE: no request in progress.
  - WAIT: countdown of D cycles.
  - BURST: beat index 0..BURST_LEN-1.
  - DONE: one turnaround cycle, then back to IDLE.
- Request acceptance:
  - A request is accepted only in IDLE, when pmem_read or pmem_write is sampled high.
  - Line index = (address >> log2(LINE_BITS/8)) mod DEPTH_LINES. Out-of-range addresses wrap.
  - Both read and write high: treated as a read; the write is ignored.
- Page tracking:
  - Page = address / PAGE_BYTES.
  - D = HIT_DELAY if the page valid bit is set and the page equals the open page; otherwise D = MISS_DELAY.
  - The open page is updated to the accessed page, and the valid bit is set, on every acceptance.
- Beats:
  - Beat k maps to line bits [64k+63:64k] (little-endian).
  - Read: pmem_rdata carries beat k while pmem_resp=1.
  - Write: pmem_wdata is captured into beat k on the rising edge that ends burst cycle k.
- Once accepted, a request always completes. Changes to read, write or address in WAIT, BURST or DONE are ignored.
- Reset:
  - Returns the block to IDLE, clears the page valid bit, and forces pmem_resp=0 and pmem_rdata=0.
  - Reset mid-burst aborts the request; beats already written remain.
  - Storage contents are not cleared by reset.
- Storage initialises to all zeros at time zero.

## Timing
- The acceptance edge is cycle 0.
- pmem_resp is high in cycles D, D+1, …, D+BURST_LEN-1, with beat k in cycle D+k.
- Cycle D+BURST_LEN is DONE; the earliest next acceptance is cycle D+BURST_LEN+1.
- pmem_resp and pmem_rdata are registered outputs. There is no combinational path from inputs to outputs.
- Output reset values: pmem_resp=0, pmem_rdata=0.

## Configuration
- PARAM_MEM_PAGE_EN defined:
  - Open-page tracking is compiled in.
  - D is HIT_DELAY or MISS_DELAY as described above.
- PARAM_MEM_PAGE_EN undefined:
  - The page register and comparator are omitted.
  - Every access uses D = MISS_DELAY.

## Test plan
- After reset, write line 0x100 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> pmem_resp high in cycles 50–53.
- Then read 0x100, with PARAM_MEM_PAGE_EN defined -> same page, so pmem_resp high in cycles 25–28, returning beats in order 0x11..11, 0x22..22, 0x33..33, 0x44..44.
- Read 0x400 (page 2), then read 0x000 -> both are misses with D=50; 0x000 returns zeros. Assert pmem_read and pmem_write together at 0x100 -> treated as a read, and data is unchanged.
- Hold pmem_read high continuously -> bursts repeat, with exactly one DONE cycle between the last beat and the next acceptance, and pmem_resp never high for more than 4 consecutive cycles.
- Assert rst low during beat 2 of a write to 0x200 -> pmem_resp drops the next cycle. A subsequent read of 0x200 is a miss (D=50) and returns the new beats 0–1 and the old beats 2–3.
- With PARAM_MEM_PAGE_EN undefined, two back-to-back reads of 0x100 -> both have D=50.
